fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter XLEN, default 32, meaning PC width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk  in  1  system clock.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port imem_req_o  out  1  fetch request.
REQ-008 SHALL have port imem_addr_o  out  XLEN  fetch address.
REQ-009 SHALL have port imem_rdata_i  in  32  instruction, valid exactly one cycle after a request; no backpressure.
REQ-010 SHALL have port redirect_i  in  1  jump/branch taken, from ex.
REQ-011 SHALL have port redirect_pc_i  in  XLEN  redirect target.
REQ-012 SHALL have port id_valid_o  out  1  instruction available to id.
REQ-013 SHALL have port id_ready_i  in  1  id accepts the instruction.
REQ-014 SHALL have port id_pc_o  out  XLEN  PC of the presented instruction.
REQ-015 SHALL have port id_inst_o  out  32  presented instruction.
REQ-016 SHALL have port count_o  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-017 SHALL hold fetch PC fpc; imem_addr_o = fpc; fpc += 4 on each issued request, wrapping modulo 2^XLEN.
REQ-018 SHALL assert imem_req_o only when count + inflight < DEPTH and redirect_i = 0, so the FIFO can never overflow.
REQ-019 SHALL set inflight for one cycle after a request and push {PC, imem_rdata_i} in that cycle unless the entry is bypassed (REQ-026) or discarded.
REQ-020 SHALL pop the head entry on id_valid_o && id_ready_i; push and pop in the same cycle leave count unchanged.
REQ-021 SHALL drive id_valid_o = (count != 0) && !redirect_i; id_pc_o/id_inst_o = head entry, 0 when empty.
REQ-022 SHALL, on redirect_i: empty the FIFO, discard the in-flight response, load fpc <= {redirect_pc_i[XLEN-1:2], 2'b00}, and treat the presented instruction as not consumed.
REQ-023 SHALL, after a redirect in cycle N, issue the target request in N+1 and present it with id_valid_o in N+3 (N+2 with bypass).
REQ-024 SHALL wrap read/write pointers modulo DEPTH; count_o SHALL reach DEPTH when full and 0 when empty.

Reset
REQ-025 SHALL on rst_n low asynchronously set fpc=RESET_PC, pointers/count/inflight=0, imem_req_o=0, id_valid_o=0, id_pc_o/id_inst_o=0; the first request is issued in the first cycle after release; reset mid-fetch discards all pending data.

Configuration
REQ-026 SHALL, with FETCH_QUEUE_BYPASS_EN defined, present an arriving response directly on id_* when the FIFO is empty, and not write it if id_ready_i=1 that cycle; without the macro, every response passes through the FIFO (minimum 1 cycle of residency).

Verification
REQ-027 SHALL cover: reset release, RESET_PC=0, id_ready_i=1 -> requests at 0x0,0x4,0x8 in consecutive cycles; id_pc_o follows 0x0,0x4,... two cycles behind (one with bypass).
REQ-028 SHALL cover: id_ready_i=0, DEPTH=4 -> count_o saturates at 4, imem_req_o stays low, no entry lost; release -> 4 pops in order, then fetch resumes.
REQ-029 SHALL cover: redirect_i with redirect_pc_i=0x103 while count_o=3 and a response in flight -> count_o=0 next cycle, stale response dropped, next request to 0x100.
REQ-030 SHALL cover: redirect_i coincident with id_ready_i=1 -> id_valid_o=0 that cycle and the head is not counted as consumed.
REQ-031 SHALL cover: fpc=0xFFFF_FFFC -> next request address 0x0000_0000.
REQ-032 SHALL cover: rst_n asserted mid-stream with count_o=2 -> all outputs 0 immediately; refetch from RESET_PC after release.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues sequential fetches and buffers responses in a DEPTH-entry FIFO for decode.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module fetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req_o,
    output logic [XLEN-1:0]        imem_addr_o,
    input  logic [31:0]            imem_rdata_i,
    input  logic                   redirect_i,
    input  logic [XLEN-1:0]        redirect_pc_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [XLEN-1:0]        id_pc_o,
    output logic [31:0]            id_inst_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];

    logic fifo_empty;
    logic fifo_push;
    logic fifo_pop;
    logic bypass_take;
    logic unused_redirect_low_bits;

    assign unused_redirect_low_bits = ^redirect_pc_i[1:0];
    assign imem_addr_o = fpc;
    assign count_o     = count;

    // Counting the in-flight response against free space guarantees the FIFO never overflows.
    // Gating with rst_n keeps the request low for the whole time reset is held.
    always_comb begin
        fifo_empty  = (count == '0);
        imem_req_o  = rst_n && !redirect_i && ((count + CW'(inflight)) < FULL);
        bypass_take = 1'b0;
        id_valid_o  = !fifo_empty && !redirect_i;
        id_pc_o     = fifo_empty ? '0 : pc_mem[rd_ptr];
        id_inst_o   = fifo_empty ? '0 : inst_mem[rd_ptr];
`ifdef FETCH_QUEUE_BYPASS_EN
        if (fifo_empty && inflight && !redirect_i) begin
            id_valid_o  = 1'b1;
            id_pc_o     = inflight_pc;
            id_inst_o   = imem_rdata_i;
            bypass_take = id_ready_i;
        end
`endif
        fifo_pop  = !fifo_empty && !redirect_i && id_ready_i;
        fifo_push = inflight && !redirect_i && !bypass_take;
    end

    // A redirect flushes everything, including the response still on its way back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc         <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (redirect_i) begin
            fpc      <= {redirect_pc_i[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req_o;
            if (imem_req_o) begin
                fpc         <= fpc + XLEN'(4);
                inflight_pc <= fpc;
            end
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            pc_mem[wr_ptr]   <= inflight_pc;
            inst_mem[wr_ptr] <= imem_rdata_i;
        end
    end

endmodule
